dmem_write_buffer: RTL and testbench
====================================

Name: dmem_write_buffer

Overview:
- Posted-write buffer placed directly downstream of the single-cycle core's data port (MemWrite / ALUResult / WriteData / ReadData), upstream of a slower word-wide data memory.
- Absorbs core stores at one per cycle and retires them to memory over a valid/ready handshake.
- Forwards buffered data to core loads so the core keeps its combinational-read view of memory.
- Asserts Stall only when a store cannot be accepted.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, byte-address width on core and memory sides.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- MemWrite  input  1  core store request this cycle.
- DataAdr  input  AW  core byte address for load or store; word aligned, bits [1:0] ignored.
- WriteData  input  32  core store data.
- ReadData  output  32  load data to core, combinational.
- Stall  output  1  store not accepted this cycle; core must hold the store.
- mem_valid  output  1  head entry is presented to memory.
- mem_ready  input  1  memory accepts the head entry this cycle.
- mem_addr  output  AW  head entry word address, with [1:0] = 0.
- mem_wdata  output  32  head entry data.
- mem_raddr  output  AW  equals DataAdr; feeds the memory's combinational read port.
- mem_rdata  input  32  memory combinational read data.
- Empty  output  1  no entries held.
- Count  output  $clog2(DEPTH)+1  number of entries held.

Behaviour:
- Storage:
  - Circular FIFO of {DataAdr[AW-1:2], WriteData} entries.
  - Head and tail pointers wrap modulo DEPTH.
  - Count ranges 0..DEPTH.
- Reset:
  - Count=0, Empty=1, mem_valid=0, pointers=0.
  - Stall=0 while reset is high.
  - Stores presented during reset are dropped.
  - Reset mid-drain discards all entries, including a head whose handshake is incomplete.
- Pop: pop = mem_valid & mem_ready.
- Accept: accept = MemWrite & ~reset & (Count<DEPTH | pop).
  - When full, a same-cycle pop frees a slot, so there is no bubble.
- Stall = MemWrite & ~reset & ~accept, combinational.
  - The core holds MemWrite, DataAdr and WriteData until Stall falls.
- Push: on accept, the entry is written at tail; it becomes visible to forwarding and Count from the next cycle.
- Count update: Count_next = Count + accept - pop. Simultaneous push and pop leaves Count unchanged.
- Drain handshake:
  - mem_valid = ~Empty, registered-state based.
  - mem_addr and mem_wdata come from the head entry and stay stable while mem_valid & ~mem_ready.
  - Entries retire strictly in FIFO order.
  - Minimum latency from store accept to first mem_valid is 1 cycle.
- Forwarding:
  - ReadData = data of the newest held entry whose word address equals DataAdr[AW-1:2]; otherwise mem_rdata.
  - The head entry being popped this cycle is still eligible.
  - A store accepted in the same cycle does not forward to itself; the read sees the prior value, matching existing dmem semantics.
- No read-side stall. ReadData is valid every cycle regardless of MemWrite.
- Width: address compare uses AW-2 bits; no arithmetic on data.

Optional Feature:
- Macro WB_COALESCE_EN.
- Defined: an accepted store whose word address matches the tail-most (newest) entry overwrites that entry's data in place.
  - Count is unchanged and no slot is allocated.
  - Exception: if that entry is the head being popped this cycle, a new slot is allocated instead.
  - When full, a coalescing store is accepted without needing a pop, so Stall is 0.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset with mem_ready=0, then store 7 to 0x64 -> next cycle Count=1, mem_valid=1, mem_addr=0x64, mem_wdata=7; hold mem_ready=0 for 3 cycles -> outputs stable; pulse mem_ready -> Count=0, Empty=1.
- mem_ready=0, stores to 0x60, 0x64, 0x68, 0x6C (DEPTH=4), then a fifth to 0x70 -> Stall=1 for the fifth; assert mem_ready in the same cycle -> Stall=0 and Count remains 4.
- Store 5 to 0x60, then 9 to 0x60 with mem_ready=0; load 0x60 -> ReadData=9, not mem_rdata; load 0x64 -> ReadData=mem_rdata.
- Store to 0x40 with DataAdr=0x40 in the same cycle -> ReadData=mem_rdata (no self-forward); the following cycle's load of 0x40 -> buffered data.
- Fill 3 entries, assert reset for 1 cycle mid-handshake -> Count=0, mem_valid=0, Stall=0; subsequent loads return mem_rdata.
- With WB_COALESCE_EN: two back-to-back stores to 0x64 (3 then 7), mem_ready=0 -> Count=1, mem_wdata=7; without the macro -> Count=2, memory sees 3 then 7.

Source files
------------

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the core data port and a slower data memory.
// Optional store coalescing into the newest entry: define WB_COALESCE_EN.
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWrite,
    input  logic [AW-1:0]          DataAdr,
    input  logic [31:0]            WriteData,
    output logic [31:0]            ReadData,
    output logic                   Stall,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [AW-1:0]          mem_raddr,
    input  logic [31:0]            mem_rdata,
    output logic                   Empty,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-3:0] adr_q [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] fwd_idx;
    logic [AW-3:0] wadr;
    logic          full;
    logic          pop;
    logic          coal;
    logic          accept;
    logic          alloc;

    assign wadr      = DataAdr[AW-1:2];
    assign Empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign mem_valid = ~Empty;
    assign pop       = mem_valid & mem_ready;
    assign mem_addr  = {adr_q[head_q], 2'b00};
    assign mem_wdata = dat_q[head_q];
    assign mem_raddr = DataAdr;
    assign Count     = count_q;

`ifdef WB_COALESCE_EN
    logic [PW-1:0] newest;
    assign newest = tail_q - PW'(1);
    // A head that leaves this cycle cannot absorb a store; allocate instead.
    assign coal = MemWrite & ~reset & ~Empty
                & (adr_q[newest] == wadr)
                & ~(pop & (count_q == CW'(1)));
`else
    assign coal = 1'b0;
`endif

    assign accept = MemWrite & ~reset & (~full | pop | coal);
    assign alloc  = accept & ~coal;
    assign Stall  = MemWrite & ~reset & ~accept;

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop)
                head_q <= head_q + PW'(1);
            if (alloc)
                tail_q <= tail_q + PW'(1);
            count_q <= count_q + CW'(alloc) - CW'(pop);
        end
    end

    // Entry storage; payload needs no reset since Count gates visibility.
    always_ff @(posedge clk) begin
        if (alloc) begin
            adr_q[tail_q] <= wadr;
            dat_q[tail_q] <= WriteData;
        end
`ifdef WB_COALESCE_EN
        else if (coal) begin
            dat_q[newest] <= WriteData;
        end
`endif
    end

    // Load forwarding: walk oldest to newest so the newest match wins.
    always_comb begin
        ReadData = mem_rdata;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (adr_q[fwd_idx] == wadr))
                ReadData = dat_q[fwd_idx];
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Self-checking bench for dmem_write_buffer.
// Reference model: a queue of {word address, data} entries.
module tb_dmem_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Stall;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata = '0;
    logic        Empty;
    logic [2:0]  Count;

    dmem_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .Empty(Empty), .Count(Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;

    logic [31:0] o_rd, o_maddr, o_wdata, last_rdata;
    logic        o_stall, o_valid, o_empty;
    logic [2:0]  o_count;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check against model, clock, update model.
    task automatic cyc(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy,
                       input logic rst);
        int n;
        logic pop, coal, acc, est;
        logic [31:0] erd;
        @(negedge clk);
        reset     = rst;
        MemWrite  = we;
        DataAdr   = a;
        WriteData = d;
        mem_ready = rdy;
        mem_rdata = $urandom;
        last_rdata = mem_rdata;
        #1;
        n    = q.size();
        pop  = (n > 0) && rdy;
        coal = 1'b0;
`ifdef WB_COALESCE_EN
        coal = we && !rst && (n > 0) && (q[n-1].a == a[31:2])
             && !(pop && n == 1);
`endif
        acc = we && !rst && ((n < DEPTH) || pop || coal);
        est = we && !rst && !acc;
        erd = mem_rdata;
        for (int i = 0; i < n; i++)
            if (q[i].a == a[31:2]) erd = q[i].d;
        o_rd = ReadData; o_stall = Stall; o_valid = mem_valid;
        o_empty = Empty; o_count = Count;
        o_maddr = mem_addr; o_wdata = mem_wdata;
        chk("stall", {31'b0, Stall}, {31'b0, est});
        chk("rdata", ReadData, erd);
        chk("valid", {31'b0, mem_valid}, {31'b0, n > 0});
        chk("empty", {31'b0, Empty}, {31'b0, n == 0});
        chk("count", {29'b0, Count}, n);
        chk("raddr", mem_raddr, a);
        if (n > 0) begin
            chk("maddr", mem_addr, {q[0].a, 2'b00});
            chk("mwdata", mem_wdata, q[0].d);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (coal) q[n-1].d = d;
            if (pop) void'(q.pop_front());
            if (acc && !coal) q.push_back('{a: a[31:2], d: d});
        end
    endtask

    logic        hw;
    logic [31:0] ha, hd;

    initial begin
        repeat (2) @(posedge clk);

        // Reset with a store present: dropped, no stall.
        cyc(1, 32'h64, 32'h1, 0, 1);
        chk("rst_stall", {31'b0, o_stall}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_count", {29'b0, o_count}, 32'd0);
        chk("rst_empty", {31'b0, o_empty}, 32'd1);

        // Single store, held handshake, then pop.
        cyc(1, 32'h64, 32'd7, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s1_count", {29'b0, o_count}, 32'd1);
        chk("s1_valid", {31'b0, o_valid}, 32'd1);
        chk("s1_maddr", o_maddr, 32'h64);
        chk("s1_wdata", o_wdata, 32'd7);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("s1_hold", o_wdata, 32'd7);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("s1_drain", {29'b0, o_count}, 32'd0);
        chk("s1_empty", {31'b0, o_empty}, 32'd1);

        // Fill to DEPTH, fifth stalls until a same-cycle pop.
        for (int i = 0; i < 4; i++) cyc(1, 32'h60 + 4 * i, i + 10, 0, 0);
        cyc(1, 32'h70, 32'd99, 0, 0);
        chk("full_stall", {31'b0, o_stall}, 32'd1);
        cyc(1, 32'h70, 32'd99, 1, 0);
        chk("full_pop_stall", {31'b0, o_stall}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("full_count", {29'b0, o_count}, 32'd4);
        chk("full_head", o_maddr, 32'h64);

        // Forwarding picks the newest match.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'h60, 32'd5, 0, 0);
        cyc(1, 32'h60, 32'd9, 0, 0);
        cyc(0, 32'h60, 0, 0, 0);
        chk("fwd_newest", o_rd, 32'd9);
        cyc(0, 32'h64, 0, 0, 0);
        chk("fwd_miss", o_rd, last_rdata);

        // No self-forwarding of a same-cycle store.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'h40, 32'hAB, 0, 0);
        chk("noself", o_rd, last_rdata);
        cyc(0, 32'h40, 0, 0, 0);
        chk("fwd_next", o_rd, 32'hAB);

        // Reset in the middle of a handshake discards everything.
        for (int i = 0; i < 3; i++) cyc(1, 32'h60 + 4 * i, i + 1, 0, 0);
        cyc(1, 32'h70, 32'd4, 1, 1);
        chk("mid_rst_stall", {31'b0, o_stall}, 32'd0);
        cyc(0, 32'h60, 0, 0, 0);
        chk("mid_rst_count", {29'b0, o_count}, 32'd0);
        chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("mid_rst_rd", o_rd, last_rdata);

        // Back-to-back stores to one word.
        cyc(1, 32'h64, 32'd3, 0, 0);
        cyc(1, 32'h64, 32'd7, 0, 0);
        cyc(0, 0, 0, 0, 0);
`ifdef WB_COALESCE_EN
        chk("coal_count", {29'b0, o_count}, 32'd1);
        chk("coal_wdata", o_wdata, 32'd7);
`else
        chk("nocoal_count", {29'b0, o_count}, 32'd2);
        chk("nocoal_first", o_wdata, 32'd3);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("nocoal_second", o_wdata, 32'd7);
`endif

        // Random traffic against the model; core holds stalled stores.
        cyc(0, 0, 0, 0, 1);
        hw = 0; ha = 0; hd = 0;
        for (int k = 0; k < 500; k++) begin
            if (!o_stall || !hw) begin
                hw = ($urandom_range(0, 2) != 0);
                ha = 32'h40 + 4 * $urandom_range(0, 5)
                   + $urandom_range(0, 3);
                hd = $urandom;
            end
            cyc(hw, ha, hd, $urandom_range(0, 2) == 0,
                $urandom_range(0, 60) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
